// File: rtl/operand_fetch_pkg.sv
// Shared processor definitions for the operand-fetch stage: widths, register
// address type and the load-use conflict test.
package operand_fetch_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_PAYLOAD_W = 40;
    localparam int unsigned REG_W         = 5;

    typedef logic [REG_W-1:0] reg_addr_t;

    // Control fields that travel with an operand pair into EX.
    typedef struct packed {
        reg_addr_t rd;
        logic      is_load;
    } op_ctrl_t;

    // A source depends on a load whose data is not yet forwardable.
    function automatic logic load_conflict(
        input reg_addr_t src,
        input logic      out_valid,
        input logic      out_is_load,
        input reg_addr_t out_rd,
        input logic      ex_load_valid,
        input reg_addr_t ex_load_rd
    );
        logic hit_out;
        logic hit_ex;
        hit_out = out_valid && out_is_load && (src == out_rd);
        hit_ex  = ex_load_valid && (src == ex_load_rd);
        return (src != '0) && (hit_out || hit_ex);
    endfunction

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// Per-source operand selection: r0 is zero, then MEM result, then write-back
// result, otherwise the register-file read data.
module operand_fwd_mux
    import operand_fetch_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  reg_addr_t         src,
    input  reg_addr_t         mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  reg_addr_t         wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] gpr_data,
    output logic [DATA_W-1:0] operand_c
);

    // The register file writes at the edge, so a write-back match must bypass it.
    always_comb begin
        operand_c = gpr_data;
        if (src == '0) begin
            operand_c = '0;
        end else if (src == mem_rd) begin
            operand_c = mem_data;
        end else if (src == wb_rd) begin
            operand_c = wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch pipeline stage: resolves both sources with forwarding, stalls on
// load-use hazards and presents a registered instruction to EX.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,

    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [REG_W-1:0]     id_rs,
    input  logic [REG_W-1:0]     id_rt,
    input  logic [REG_W-1:0]     id_rd,
    input  logic                 id_is_load,
    input  logic [PAYLOAD_W-1:0] id_payload,

    output logic [REG_W-1:0]     gpr_addr_a,
    output logic [REG_W-1:0]     gpr_addr_b,
    input  logic [DATA_W-1:0]    gpr_data_a,
    input  logic [DATA_W-1:0]    gpr_data_b,

    input  logic [REG_W-1:0]     mem_rd,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic [REG_W-1:0]     wb_rd,
    input  logic [DATA_W-1:0]    wb_data,

    input  logic                 ex_load_valid,
    input  logic [REG_W-1:0]     ex_load_rd,

    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [DATA_W-1:0]    op_a,
    output logic [DATA_W-1:0]    op_b,
    output logic [REG_W-1:0]     op_rd,
    output logic                 op_is_load,
    output logic [PAYLOAD_W-1:0] op_payload
);

    logic [DATA_W-1:0] fwd_a_c;
    logic [DATA_W-1:0] fwd_b_c;
    logic              hazard_c;
    logic              advance_c;
    logic              capture_c;

    logic                 valid_q;
    logic [DATA_W-1:0]    a_q;
    logic [DATA_W-1:0]    b_q;
    op_ctrl_t             ctrl_q;
    logic [PAYLOAD_W-1:0] payload_q;

    assign gpr_addr_a = id_rs;
    assign gpr_addr_b = id_rt;

    operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
        .src       (id_rs),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .gpr_data  (gpr_data_a),
        .operand_c (fwd_a_c)
    );

    operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
        .src       (id_rt),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .gpr_data  (gpr_data_b),
        .operand_c (fwd_b_c)
    );

    // Handshake: the stage moves when the output slot is free or being drained.
    always_comb begin
        hazard_c  = id_valid &&
                    (load_conflict(id_rs, valid_q, ctrl_q.is_load, ctrl_q.rd,
                                   ex_load_valid, ex_load_rd) ||
                     load_conflict(id_rt, valid_q, ctrl_q.is_load, ctrl_q.rd,
                                   ex_load_valid, ex_load_rd));
        advance_c = !valid_q || op_ready;
        id_ready  = advance_c && !hazard_c && !flush;
        capture_c = id_valid && id_ready;
    end

    // Output register: flush beats capture; a stall holds every field as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            payload_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture_c) begin
            valid_q        <= 1'b1;
            a_q            <= fwd_a_c;
            b_q            <= fwd_b_c;
            ctrl_q.rd      <= id_rd;
            ctrl_q.is_load <= id_is_load;
            payload_q      <= id_payload;
        end else if (advance_c) begin
            valid_q <= 1'b0;
        end
    end

    assign op_valid   = valid_q;
    assign op_a       = a_q;
    assign op_b       = b_q;
    assign op_rd      = ctrl_q.rd;
    assign op_is_load = ctrl_q.is_load;
    assign op_payload = payload_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and result width.
REQ-002 SHALL have parameter PAYLOAD_W, default 40, opaque immediate/control bits passed through unchanged.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  in  1  discard held and incoming instruction.
REQ-006 SHALL have port id_valid  in  1  decoded instruction offered.
REQ-007 SHALL have port id_ready  out  1  stage accepts instruction this cycle.
REQ-008 SHALL have port id_rs  in  5  source A register.
REQ-009 SHALL have port id_rt  in  5  source B register.
REQ-010 SHALL have port id_rd  in  5  destination, 0 means no write.
REQ-011 SHALL have port id_is_load  in  1  instruction is a load.
REQ-012 SHALL have port id_payload  in  PAYLOAD_W  opaque pass-through.
REQ-013 SHALL have port gpr_addr_a  out  5  register-file read address A, equal to id_rs.
REQ-014 SHALL have port gpr_addr_b  out  5  register-file read address B, equal to id_rt.
REQ-015 SHALL have port gpr_data_a  in  DATA_W  combinational read data A.
REQ-016 SHALL have port gpr_data_b  in  DATA_W  combinational read data B.
REQ-017 SHALL have port mem_rd  in  5  MEM-stage destination, 0 means none.
REQ-018 SHALL have port mem_data  in  DATA_W  MEM-stage result.
REQ-019 SHALL have port wb_rd  in  5  write-back destination, also the register-file write address.
REQ-020 SHALL have port wb_data  in  DATA_W  write-back data, also the register-file write data.
REQ-021 SHALL have port ex_load_valid  in  1  EX stage holds a load.
REQ-022 SHALL have port ex_load_rd  in  5  destination of that load.
REQ-023 SHALL have port op_valid  out  1  output register holds an instruction.
REQ-024 SHALL have port op_ready  in  1  EX accepts output this cycle.
REQ-025 SHALL have port op_a, op_b  out  DATA_W each  resolved operands.
REQ-026 SHALL have port op_rd, op_is_load, op_payload  out  5/1/PAYLOAD_W  registered copies of id fields.

Function
REQ-027 Operand resolution, per source, nonzero register only: match mem_rd first, then wb_rd, else GPR data; register 0 always yields 0.
REQ-028 A wb_rd forward is mandatory: the register-file write lands at the clock edge, so same-cycle GPR reads return stale data.
REQ-029 Hazard: id_valid and a nonzero source equal to op_rd with op_valid&op_is_load, or to ex_load_rd with ex_load_valid.
REQ-030 advance = ~op_valid | op_ready; id_ready = advance & ~hazard & ~flush.
REQ-031 Capture on id_valid&id_ready: all op_* fields loaded on the next edge, op_valid=1, using forwarding values of the capture cycle; latency 1 cycle.
REQ-032 On advance without capture (hazard or no id_valid), op_valid is cleared (bubble); on ~advance all op_* fields hold, with no re-resolution.
REQ-033 flush clears op_valid on the next edge, regardless of op_ready or hazard; flush has priority over capture.
REQ-034 While a hazard is present, id_ready stays 0 each cycle until it clears; no cycle limit applies.
REQ-035 Back-to-back captures every cycle while op_ready=1 and no hazard, with no throughput loss.

Reset
REQ-036 rst_n low asynchronously clears op_valid, op_a, op_b, op_rd, op_is_load and op_payload to 0; id_ready follows REQ-030 combinationally.

Structure
REQ-037 DATA_W, PAYLOAD_W and register-address width of 5 SHALL live in the shared processor package.
REQ-038 The per-source priority mux SHALL be one sub-module, operand_fwd_mux, instantiated twice.

Verification
REQ-039 GPR r5=0x11, id rs=5 rt=0 -> next cycle op_a=0x11, op_b=0.
REQ-040 mem_rd=5/0xAA and wb_rd=5/0xBB together -> op_a=0xAA; mem_rd=0 -> op_a=0xBB; mem_rd=0,wb_rd=0 with wb_data=0xFF -> op_a=GPR value.
REQ-041 Load to r7 in output register, next id rs=7 -> id_ready=0 one cycle, bubble; then ex_load_valid=1, ex_load_rd=7 holds id_ready=0; capture once mem_rd=7/0x1234 forwards -> op_a=0x1234.
REQ-042 op_ready=0 for 3 cycles with op_valid=1 -> op_* unchanged, id_ready=0; op_ready=1 -> next instruction captured on the following edge.
REQ-043 flush asserted with id_valid=1 and op_ready=0 -> op_valid=0 next cycle, instruction not captured; rst_n pulse mid-stall -> all op_* cleared immediately.
